// File: rtl/activity_monitor.sv
// Per-channel activity monitor: edge counts, periods and stuck flags
// over a timed run window, with handshaked progress marks.
module activity_monitor #(
  parameter int          NUM_CH        = 4,
  parameter int          CNT_W         = 16,
  parameter int          STUCK_LIMIT   = 1000,
  parameter int unsigned RUN_CYCLES    = 100000,
  parameter int          MARK_INTERVAL = 8,
  localparam int         SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mark_ready,
  output logic [CNT_W-1:0]  edge_cnt,
  output logic [CNT_W-1:0]  period,
  output logic [NUM_CH-1:0] stuck,
  output logic [31:0]       cycle_cnt,
  output logic              mark_valid,
  output logic [15:0]       mark_idx,
  output logic              mark_ovr,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [31:0] RUNC  = 32'(RUN_CYCLES);
  localparam logic [31:0] MMASK = 32'(MARK_INTERVAL - 1);
  localparam logic [CNT_W-1:0] CMAX   = '1;
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STUCK_LIMIT - 1);

  logic [1:0]        state_q, state_d;
  logic [31:0]       cyc_q, cyc_d, cyc_inc;
  logic [NUM_CH-1:0] ch1_q, ch2_q;
  logic [NUM_CH-1:0] rise, chg;
  logic [NUM_CH-1:0] seen_q, seen_d;
  logic [NUM_CH-1:0] stuck_q, stuck_d;
  logic [CNT_W-1:0]  edge_q [NUM_CH];
  logic [CNT_W-1:0]  edge_d [NUM_CH];
  logic [CNT_W-1:0]  per_q  [NUM_CH];
  logic [CNT_W-1:0]  per_d  [NUM_CH];
  logic [CNT_W-1:0]  ivl_q  [NUM_CH];
  logic [CNT_W-1:0]  ivl_d  [NUM_CH];
  logic [CNT_W-1:0]  idle_q [NUM_CH];
  logic [CNT_W-1:0]  idle_d [NUM_CH];
  logic              mv_q, mv_d;
  logic              ovr_q, ovr_d;
  logic [15:0]       idx_q, idx_d;
  logic              run, enter, gen, acc;

  assign run     = (state_q == S_RUN);
  assign enter   = start && !run;
  assign cyc_inc = cyc_q + 32'd1;
  // Marks key off the count being written, so the final cycle still marks.
  assign gen     = run && ((cyc_inc & MMASK) == 32'd0);
  assign acc     = mv_q && mark_ready;
  assign rise    = ch1_q & ~ch2_q;
  assign chg     = ch1_q ^ ch2_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    if (enter) begin
      state_d = S_RUN;
      cyc_d   = 32'd0;
    end else if (run) begin
      cyc_d = cyc_inc;
      if (cyc_inc == RUNC) state_d = S_DONE;
    end
  end

  always_comb begin
    mv_d  = mv_q;
    idx_d = idx_q;
    ovr_d = ovr_q;
    if (enter) begin
      mv_d  = 1'b0;
      idx_d = 16'd0;
    end else begin
      if (acc) mv_d = 1'b0;
      if (gen && (!mv_q || acc)) begin
        mv_d  = 1'b1;
        idx_d = idx_q + 16'd1;
      end
    end
    if (clear) ovr_d = 1'b0;
    else if (gen && mv_q && !acc) ovr_d = 1'b1;
  end

  always_comb begin
    seen_d  = seen_q;
    stuck_d = stuck_q;
    for (int i = 0; i < NUM_CH; i++) begin
      edge_d[i] = edge_q[i];
      per_d[i]  = per_q[i];
      ivl_d[i]  = ivl_q[i];
      idle_d[i] = idle_q[i];
      if (enter || clear) begin
        edge_d[i]  = '0;
        per_d[i]   = '0;
        ivl_d[i]   = '0;
        idle_d[i]  = '0;
        seen_d[i]  = 1'b0;
        stuck_d[i] = 1'b0;
      end else if (run) begin
        if (rise[i]) begin
          if (edge_q[i] != CMAX) edge_d[i] = edge_q[i] + ONE;
          if (seen_q[i]) per_d[i] = ivl_q[i];
          ivl_d[i]  = ONE;
          seen_d[i] = 1'b1;
        end else if (ivl_q[i] != CMAX) begin
          ivl_d[i] = ivl_q[i] + ONE;
        end
        if (chg[i]) begin
          idle_d[i]  = '0;
          stuck_d[i] = 1'b0;
        end else begin
          if (idle_q[i] != CMAX) idle_d[i] = idle_q[i] + ONE;
          if (idle_q[i] >= LIM_M1) stuck_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      ch1_q   <= '0;
      ch2_q   <= '0;
      seen_q  <= '0;
      stuck_q <= '0;
      mv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        edge_q[i] <= '0;
        per_q[i]  <= '0;
        ivl_q[i]  <= '0;
        idle_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ch1_q   <= ch_in;
      ch2_q   <= ch1_q;
      seen_q  <= seen_d;
      stuck_q <= stuck_d;
      mv_q    <= mv_d;
      ovr_q   <= ovr_d;
      idx_q   <= idx_d;
      for (int i = 0; i < NUM_CH; i++) begin
        edge_q[i] <= edge_d[i];
        per_q[i]  <= per_d[i];
        ivl_q[i]  <= ivl_d[i];
        idle_q[i] <= idle_d[i];
      end
    end
  end

  always_comb begin
    edge_cnt = '0;
    period   = '0;
    if (int'(sel) < NUM_CH) begin
      edge_cnt = edge_q[sel];
      period   = per_q[sel];
    end
  end

  assign stuck      = stuck_q;
  assign cycle_cnt  = cyc_q;
  assign mark_valid = mv_q;
  assign mark_idx   = idx_q;
  assign mark_ovr   = ovr_q;
  assign busy       = run;
  assign done       = (state_q == S_DONE);

endmodule
